// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with valid/ready handshakes on both sides.
// Signed operands are multiplied as magnitudes and the product sign is applied on exit.
module shift_add_mult #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_A,
  input  logic [WIDTH-1:0]   i_B,
  input  logic               i_abort,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_P,
  output logic               o_busy
);

  // state | meaning
  // IDLE  | waiting for operands, o_ready high
  // CALC  | one multiplier bit consumed per cycle, o_busy high
  // DONE  | product held on o_P until consumer takes it, o_valid high
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic               signed_mode;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
  always_comb begin
    signed_mode = (SIGNED_EN != 0) && i_signed;
    mag_a       = (signed_mode && i_A[WIDTH-1]) ? -i_A : i_A;
    mag_b       = (signed_mode && i_B[WIDTH-1]) ? -i_B : i_B;
    sum         = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      o_P    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            neg    <= signed_mode && (i_A[WIDTH-1] ^ i_B[WIDTH-1]);
            state  <= CALC;
          end
        end
        CALC: begin
          if (i_abort) begin
            state <= IDLE;
          end else if (mplier[WIDTH-1:1] == '0) begin
            // Last set bit consumed; -0 is still 0 so a zero product never turns nonzero.
            o_P   <= neg ? -sum : sum;
            state <= DONE;
          end else begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        DONE: begin
          if (i_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == CALC);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_shift_add_mult;
  localparam int W = 8;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b0;
  logic           valid   = 1'b0;
  logic           valid_u = 1'b0;
  logic           sgn     = 1'b0;
  logic           abort   = 1'b0;
  logic           rdy     = 1'b0;
  logic [W-1:0]   a       = '0;
  logic [W-1:0]   b       = '0;
  logic           o_ready, o_valid, o_busy;
  logic           u_ready, u_valid, u_busy;
  logic [2*W-1:0] o_p, u_p;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(W), .SIGNED_EN(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
    .i_signed(sgn), .i_A(a), .i_B(b), .i_abort(abort), .o_valid(o_valid),
    .i_ready(rdy), .o_P(o_p), .o_busy(o_busy)
  );

  shift_add_mult #(.WIDTH(W), .SIGNED_EN(0)) u_uns (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_u), .o_ready(u_ready),
    .i_signed(sgn), .i_A(a), .i_B(b), .i_abort(abort), .o_valid(u_valid),
    .i_ready(rdy), .o_P(u_p), .o_busy(u_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rs);
    int sa, sb, p;
    sa = rs ? int'($signed(ra)) : int'({24'b0, ra});
    sb = rs ? int'($signed(rb)) : int'({24'b0, rb});
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  function automatic int ref_cycles(input logic [W-1:0] rb, input logic rs);
    int mag, n;
    mag = (rs && rb[W-1]) ? (256 - int'({24'b0, rb})) : int'({24'b0, rb});
    n = 1;
    for (int i = 0; i < W; i++) if (mag >= (1 << i)) n = i + 1;
    return n;
  endfunction

  // Full operation on the signed-capable DUT; optionally holds i_valid high throughout.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input int hold, input bit keep_valid);
    logic [2*W-1:0] exp_p;
    int n;
    exp_p = ref_prod(ta, tb_v, ts);
    a = ta; b = tb_v; sgn = ts; valid = 1'b1;
    @(posedge clk); #1;
    if (!keep_valid) valid = 1'b0;
    chk("busy_after_accept", o_busy, 1);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!o_valid && n < 40);
    chk("calc_cycles", n, ref_cycles(tb_v, ts));
    chk("product", o_p, exp_p);
    for (int i = 0; i < hold; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("hold_product", o_p, exp_p);
      chk("hold_valid", o_valid, 1);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("idle_after_handoff", o_ready, 1);
    chk("valid_after_handoff", o_valid, 0);
    chk("product_kept", o_p, exp_p);
    valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int n;
    #12;
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_p", o_p, 0);
    chk("rst_u_p", u_p, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd13, 8'd11, 1'b0, 3, 1'b0);
    run_op(8'h80, 8'h80, 1'b1, 0, 1'b0);
    run_op(8'hFD, 8'd5, 1'b1, 0, 1'b0);
    chk("neg_product", o_p, 16'hFFF1);
    run_op(8'd255, 8'd0, 1'b0, 0, 1'b0);
    run_op(8'd0, 8'h80, 1'b0, 0, 1'b0);
    run_op(8'd0, 8'hFB, 1'b1, 0, 1'b0);

    // Abort on second CALC cycle; prior result must survive.
    run_op(8'd7, 8'd3, 1'b0, 0, 1'b0);
    a = 8'd100; b = 8'd200; sgn = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", o_ready, 1);
    chk("abort_p", o_p, 21);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen |= o_valid;
      @(posedge clk); #1;
    end
    chk("abort_no_valid", seen, 0);
    run_op(8'd7, 8'd6, 1'b0, 0, 1'b0);

    // Consumer stalls 10 cycles while producer keeps requesting.
    run_op(8'd57, 8'd99, 1'b0, 10, 1'b1);
    run_op(8'd3, 8'd4, 1'b0, 0, 1'b0);

    // SIGNED_EN=0 instance ignores i_signed.
    a = 8'hFF; b = 8'd2; sgn = 1'b1; valid_u = 1'b1;
    @(posedge clk); #1;
    valid_u = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!u_valid && n < 40);
    chk("uns_cycles", n, 2);
    chk("uns_product", u_p, 510);
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    chk("uns_idle", u_ready, 1);

    // Asynchronous reset in the middle of CALC.
    a = 8'd255; b = 8'd255; sgn = 1'b0; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", o_ready, 1);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_p", o_p, 0);
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen |= o_valid;
    end
    chk("midrst_no_valid", seen, 0);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    run_op(8'd9, 8'd9, 1'b0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL provide parameter SIGNED_EN, default 1; 1 = i_signed honoured, 0 = i_signed ignored (always unsigned).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_valid  input  1  operand request, qualified by o_ready.
REQ-006 SHALL have port o_ready  output  1  block can accept operands.
REQ-007 SHALL have port i_signed  input  1  operand mode, sampled with operands.
REQ-008 SHALL have port i_A  input  WIDTH  multiplicand.
REQ-009 SHALL have port i_B  input  WIDTH  multiplier.
REQ-010 SHALL have port i_abort  input  1  cancel operation in progress.
REQ-011 SHALL have port o_valid  output  1  result available.
REQ-012 SHALL have port i_ready  input  1  consumer accepts result, qualified by o_valid.
REQ-013 SHALL have port o_P  output  2*WIDTH  product, two's complement when signed.
REQ-014 SHALL have port o_busy  output  1  high in CALC state.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; o_ready = (state==IDLE), o_busy = (state==CALC), o_valid = (state==DONE), all registered-state decodes.
REQ-016 SHALL accept operands on the edge where i_valid && o_ready; i_A, i_B, i_signed captured; state -> CALC.
REQ-017 SHALL, in signed mode, convert each operand to magnitude (WIDTH-bit unsigned) and record sign = sign(A) XOR sign(B); -2^(WIDTH-1) SHALL yield magnitude 2^(WIDTH-1) without error.
REQ-018 SHALL per CALC cycle examine multiplier LSB: if 1 add shifted multiplicand to 2*WIDTH accumulator; then shift multiplicand left 1 and multiplier right 1.
REQ-019 SHALL leave CALC after the cycle in which the remaining (pre-shift) multiplier has no set bits above the current LSB; CALC duration = max(1, position of highest set bit of |B| + 1) cycles, never more than WIDTH.
REQ-020 SHALL, on CALC exit, load o_P with accumulator (negated if sign=1 in signed mode) and enter DONE; o_P valid in the same cycle o_valid rises.
REQ-021 SHALL hold o_P and o_valid stable in DONE until i_ready=1; on that edge state -> IDLE.
REQ-022 SHALL keep o_P unchanged outside the DONE-entry update (holds last result in IDLE/CALC).
REQ-023 SHALL on i_abort=1 in CALC return to IDLE next edge, o_valid never asserted, o_P unchanged; i_abort ignored in IDLE and DONE.
REQ-024 SHALL ignore i_valid while not in IDLE; no operand capture in same cycle as result handoff (minimum 1 IDLE cycle between operations).
REQ-025 SHALL produce exact results: no overflow possible, product width 2*WIDTH.
REQ-026 SHALL treat zero operand: B=0 -> 1 CALC cycle, o_P=0; A=0 -> normal duration, o_P=0; zero result never negated to nonzero.

Reset
REQ-027 SHALL on i_rst_n=0 immediately force state IDLE, o_P=0, accumulator/operand registers=0; o_ready=1, o_valid=0, o_busy=0.
REQ-028 SHALL on reset mid-CALC or mid-DONE discard the operation with no o_valid pulse after release.
REQ-029 SHALL accept a new operation on the first rising edge after reset release with i_valid=1.

Verification
REQ-030 WIDTH=8, unsigned A=13, B=11 -> o_valid after 4 CALC cycles, o_P=143; held until i_ready.
REQ-031 WIDTH=8, signed A=-128, B=-128 -> 8 CALC cycles, o_P=16384; A=-3, B=5 -> 3 CALC cycles, o_P=0xFFF1 (-15).
REQ-032 B=0, A=255 unsigned -> 1 CALC cycle, o_P=0; A=0, B=0x80 -> 8 CALC cycles, o_P=0.
REQ-033 i_abort at 2nd CALC cycle of 100x200 -> IDLE next edge, o_valid stays 0, o_P keeps prior value; following op 7x6 -> o_P=42.
REQ-034 i_ready held 0 for 10 cycles in DONE with i_valid=1 -> o_P stable, no capture; i_ready=1 -> IDLE, next op accepted one cycle later.
REQ-035 i_rst_n asserted mid-CALC (async, between edges) -> outputs to reset values immediately; no o_valid after release; SIGNED_EN=0 with i_signed=1, A=0xFF, B=2 -> o_P=510.
